mul_float_norm: RTL and testbench
=================================

// Module: mul_float_norm
// PURPOSE
//  Normalise/round/pack stage of the FP32 multiplier; sits directly after mul_float_cal.
//  Takes its raw sign, biased 10-bit exponent sum, 48-bit mantissa product and 6 exception
//  flags; emits an IEEE754 single result plus status flags. 2-cycle pipeline, same
//  REQ/VALID/BUSY stall protocol as upstream. Round-to-nearest-even, flush-to-zero.
// PARAMETERS
//  none (format fixed to FP32; constants live in mul_float_pkg)
// PORTS
//  iCLOCK                in   1   clock
//  inRESET               in   1   async reset, active-low
//  iRESET_SYNC           in   1   sync reset, active-high, clears pipe
//  iDATA_REQ             in   1   input valid
//  oDATA_BUSY            out  1   stall to upstream (= iDATA_BUSY, combinational)
//  iDATA_SIGN            in   1   result sign
//  iDATA_EXP             in   10  expA+expB-127, two's complement signed
//  iDATA_FRACT           in   48  {1,fA}*{1,fB}, binary point between bit46 and bit45
//  iDATA_EXCEPT_EXP_A0/B0     in 1  operand exponent field == 0
//  iDATA_EXCEPT_EXP_A1/B1     in 1  operand exponent field == 8'hFF
//  iDATA_EXCEPT_FRACT_A0/B0   in 1  operand fraction field == 0
//  oDATA_VALID           out  1   output valid
//  iDATA_BUSY            in   1   downstream stall
//  oDATA_RESULT          out  32  packed FP32 result
//  oDATA_OVERFLOW/UNDERFLOW/INEXACT/INVALID  out 1 each  status flags
// BEHAVIOUR
//  Reset (async or sync): both valid bits 0, all data/flag regs 0 -> oDATA_RESULT=0, flags 0.
//  Handshake: every stage reg loads only when !iDATA_BUSY; stage valid <= previous valid.
//   iDATA_BUSY=1 freezes whole pipe, output held stable; no drop, no duplicate. Latency 2.
//  Stage 0 (classify + normalise):
//   nanA = EXP_A1 & !FRACT_A0 (likewise B); infX = EXP_X1 & FRACT_X0; zeroX = EXP_X0 (FTZ).
//   class priority: NAN (either nan, or inf*zero) > INF > ZERO > NORMAL.
//   fract[47]=1: man=fract[46:24], g=fract[23], s=|fract[22:0], e=exp+1
//   else:        man=fract[45:23], g=fract[22], s=|fract[21:0], e=exp
//   e is sign-extended to 11 bits; register {class, sign, e, man, g, s}.
//  Stage 1 (round + pack):
//   up = g & (s | man[0]); {c,m} = man+up (24b); e' = e + c; m = 0 when c.
//   NORMAL: e'>=255 -> {sign,8'hFF,0}, OVERFLOW=1, INEXACT=1;
//           e'<=0   -> {sign,31'h0},   UNDERFLOW=1, INEXACT=1;
//           else    -> {sign,e'[7:0],m}, INEXACT = g|s. Range checked AFTER rounding.
//   NAN  -> 32'h7FC0_0000, INVALID=1. INF -> {sign,8'hFF,23'h0}. ZERO -> {sign,31'h0}.
//   Special classes: OVERFLOW/UNDERFLOW/INEXACT = 0.
//  Flags are per-result (non-sticky), qualified by oDATA_VALID.
//  iRESET_SYNC mid-operation: pending results discarded, oDATA_VALID=0 next cycle.
//  iDATA_REQ while oDATA_BUSY=1: not captured; upstream must hold it.
// STRUCTURE
//  mul_float_pkg: ieee754_float struct, EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000,
//   class enum {CLS_NORMAL, CLS_ZERO, CLS_INF, CLS_NAN}.
//  Sub-module mul_float_pipe_reg #(PL_N): valid+data register with busy-gated load and
//   async/sync clear; instantiated once per stage with a packed stage struct.
// TESTING
//  1) exp=10'd127, fract=48'h9000_0000_0000 (1.5*1.5) -> 2 cycles later 32'h4010_0000, flags 0.
//  2) exp=127, fract=48'h4000_0040_0000 -> 32'h3F80_0000 INEXACT=1 (tie, even kept);
//     fract=48'h4000_00C0_0000 -> 32'h3F80_0002 INEXACT=1 (tie, round up).
//  3) exp=10'd254, fract[47]=1 -> 32'h7F80_0000 OVERFLOW=1 INEXACT=1;
//     exp=10'h3F0 (-16), sign=1 -> 32'h8000_0000 UNDERFLOW=1.
//  4) EXP_A1=1,FRACT_A0=1,EXP_B0=1 -> 32'h7FC0_0000 INVALID=1; EXP_A1=1,FRACT_A0=0 -> same.
//  5) 3 back-to-back reqs, iDATA_BUSY=1 for 2 cycles after first valid -> output held,
//     all 3 results appear in order, none lost/duplicated; oDATA_BUSY mirrors iDATA_BUSY.
//  6) inRESET low (and separately iRESET_SYNC high) with 2 results in flight ->
//     oDATA_VALID=0, oDATA_RESULT=0; next request after release returns correct value.

Source files
------------

// File: rtl/mul_float_pkg.sv
// Shared FP32 types and constants for the multiplier normalise/round/pack stages.
// No logic, no latency.
// No flow control; types only.
package mul_float_pkg;

   localparam int          EXP_BIAS = 127;
   localparam int          EXP_MAX  = 255;
   localparam logic [31:0] QNAN     = 32'h7FC0_0000;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] fract;
   } ieee754_float;

   typedef enum logic [1:0] {
      CLS_NORMAL,
      CLS_ZERO,
      CLS_INF,
      CLS_NAN
   } float_class_t;

   // Stage 0 -> stage 1: classified, normalised but not yet rounded
   typedef struct packed {
      float_class_t       cls;
      logic               sign;
      logic signed [10:0] exp;
      logic [22:0]        man;
      logic               guard;
      logic               sticky;
   } norm_stage_t;

   // Stage 1 -> output: packed result plus per-result status
   typedef struct packed {
      ieee754_float result;
      logic         overflow;
      logic         underflow;
      logic         inexact;
      logic         invalid;
   } pack_stage_t;

endpackage

// File: rtl/mul_float_pipe_reg.sv
// Valid + data pipeline register shared by both multiplier output stages.
// Latency 1 cycle.
// Holds contents while busy is high; sync clear overrides the hold.
module mul_float_pipe_reg #(
   parameter int PL_N = 1
) (
   input  logic            iCLOCK,
   input  logic            inRESET,
   input  logic            iRESET_SYNC,
   input  logic            busy,
   input  logic            in_vld,
   input  logic [PL_N-1:0] in_dat,
   output logic            out_vld,
   output logic [PL_N-1:0] out_dat
);

   // Load valid and data together whenever downstream is not stalling
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         out_vld <= 1'b0;
         out_dat <= '0;
      end else if (iRESET_SYNC) begin
         out_vld <= 1'b0;
         out_dat <= '0;
      end else if (!busy) begin
         out_vld <= in_vld;
         out_dat <= in_dat;
      end
   end

endmodule

// File: rtl/mul_float_norm.sv
// FP32 multiplier normalise/round/pack: classify + normalise, then RNE round + pack, FTZ.
// Latency 2 cycles.
// iDATA_BUSY freezes both stages; oDATA_BUSY is iDATA_BUSY passed straight through.
module mul_float_norm
   import mul_float_pkg::*;
(
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iRESET_SYNC,
   input  logic        iDATA_REQ,
   output logic        oDATA_BUSY,
   input  logic        iDATA_SIGN,
   input  logic [9:0]  iDATA_EXP,
   input  logic [47:0] iDATA_FRACT,
   input  logic        iDATA_EXCEPT_EXP_A0,
   input  logic        iDATA_EXCEPT_EXP_B0,
   input  logic        iDATA_EXCEPT_EXP_A1,
   input  logic        iDATA_EXCEPT_EXP_B1,
   input  logic        iDATA_EXCEPT_FRACT_A0,
   input  logic        iDATA_EXCEPT_FRACT_B0,
   output logic        oDATA_VALID,
   input  logic        iDATA_BUSY,
   output logic [31:0] oDATA_RESULT,
   output logic        oDATA_OVERFLOW,
   output logic        oDATA_UNDERFLOW,
   output logic        oDATA_INEXACT,
   output logic        oDATA_INVALID
);

   localparam int S0_W = $bits(norm_stage_t);
   localparam int S1_W = $bits(pack_stage_t);

   logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic signed [10:0] exp_ext;

   norm_stage_t s0_d, s0_q;
   pack_stage_t s1_d, s1_q;
   logic [S0_W-1:0] s0_q_raw;
   logic [S1_W-1:0] s1_q_raw;
   logic s0_vld, s1_vld;

   logic               round_up;
   logic [23:0]        man_rnd;
   logic signed [10:0] exp_rnd;
   logic [22:0]        man_final;

   // Denormal operands arrive with a zero exponent field and are flushed to zero
   assign nan_a   = iDATA_EXCEPT_EXP_A1 & ~iDATA_EXCEPT_FRACT_A0;
   assign nan_b   = iDATA_EXCEPT_EXP_B1 & ~iDATA_EXCEPT_FRACT_B0;
   assign inf_a   = iDATA_EXCEPT_EXP_A1 &  iDATA_EXCEPT_FRACT_A0;
   assign inf_b   = iDATA_EXCEPT_EXP_B1 &  iDATA_EXCEPT_FRACT_B0;
   assign zero_a  = iDATA_EXCEPT_EXP_A0;
   assign zero_b  = iDATA_EXCEPT_EXP_B0;
   assign exp_ext = {iDATA_EXP[9], iDATA_EXP};

   // Stage 0: pick the operand class and align the product so the hidden 1 drops out
   always_comb begin
      s0_d      = '0;
      s0_d.sign = iDATA_SIGN;
      if (nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a)) begin
         s0_d.cls = CLS_NAN;
      end else if (inf_a | inf_b) begin
         s0_d.cls = CLS_INF;
      end else if (zero_a | zero_b) begin
         s0_d.cls = CLS_ZERO;
      end else begin
         s0_d.cls = CLS_NORMAL;
      end
      // Product of two [1,2) significands lies in [1,4); bit 47 set means >= 2
      if (iDATA_FRACT[47]) begin
         s0_d.man    = iDATA_FRACT[46:24];
         s0_d.guard  = iDATA_FRACT[23];
         s0_d.sticky = |iDATA_FRACT[22:0];
         s0_d.exp    = exp_ext + 11'sd1;
      end else begin
         s0_d.man    = iDATA_FRACT[45:23];
         s0_d.guard  = iDATA_FRACT[22];
         s0_d.sticky = |iDATA_FRACT[21:0];
         s0_d.exp    = exp_ext;
      end
   end

   mul_float_pipe_reg #(.PL_N(S0_W)) u_stage0 (
      .iCLOCK      (iCLOCK),
      .inRESET     (inRESET),
      .iRESET_SYNC (iRESET_SYNC),
      .busy        (iDATA_BUSY),
      .in_vld      (iDATA_REQ),
      .in_dat      (s0_d),
      .out_vld     (s0_vld),
      .out_dat     (s0_q_raw)
   );

   assign s0_q = norm_stage_t'(s0_q_raw);

   // Stage 1: round to nearest even, then range-check the rounded exponent and pack
   always_comb begin
      s1_d      = '0;
      round_up  = s0_q.guard & (s0_q.sticky | s0_q.man[0]);
      man_rnd   = {1'b0, s0_q.man} + {23'b0, round_up};
      // A carry out of the mantissa means 1.111..1 rounded to 10.0: bump exponent
      exp_rnd   = s0_q.exp + $signed({10'b0, man_rnd[23]});
      man_final = man_rnd[23] ? 23'h0 : man_rnd[22:0];
      case (s0_q.cls)
         CLS_NAN: begin
            s1_d.result  = ieee754_float'(QNAN);
            s1_d.invalid = 1'b1;
         end
         CLS_INF: begin
            s1_d.result = '{sign: s0_q.sign, exp: 8'hFF, fract: 23'h0};
         end
         CLS_ZERO: begin
            s1_d.result = '{sign: s0_q.sign, exp: 8'h00, fract: 23'h0};
         end
         default: begin
            if (exp_rnd >= $signed(11'(EXP_MAX))) begin
               s1_d.result   = '{sign: s0_q.sign, exp: 8'hFF, fract: 23'h0};
               s1_d.overflow = 1'b1;
               s1_d.inexact  = 1'b1;
            end else if (exp_rnd <= 11'sd0) begin
               s1_d.result    = '{sign: s0_q.sign, exp: 8'h00, fract: 23'h0};
               s1_d.underflow = 1'b1;
               s1_d.inexact   = 1'b1;
            end else begin
               s1_d.result  = '{sign: s0_q.sign, exp: exp_rnd[7:0], fract: man_final};
               s1_d.inexact = s0_q.guard | s0_q.sticky;
            end
         end
      endcase
   end

   mul_float_pipe_reg #(.PL_N(S1_W)) u_stage1 (
      .iCLOCK      (iCLOCK),
      .inRESET     (inRESET),
      .iRESET_SYNC (iRESET_SYNC),
      .busy        (iDATA_BUSY),
      .in_vld      (s0_vld),
      .in_dat      (s1_d),
      .out_vld     (s1_vld),
      .out_dat     (s1_q_raw)
   );

   assign s1_q            = pack_stage_t'(s1_q_raw);
   assign oDATA_BUSY      = iDATA_BUSY;
   assign oDATA_VALID     = s1_vld;
   assign oDATA_RESULT    = s1_q.result;
   assign oDATA_OVERFLOW  = s1_q.overflow;
   assign oDATA_UNDERFLOW = s1_q.underflow;
   assign oDATA_INEXACT   = s1_q.inexact;
   assign oDATA_INVALID   = s1_q.invalid;

endmodule

// File: tb/tb_mul_float_norm.sv
// Self-checking bench for mul_float_norm: directed table, stall/reset sequences,
// and randomized traffic with random downstream stalls against a numeric model.
module tb_mul_float_norm;

   logic        iCLOCK = 1'b0;
   logic        inRESET;
   logic        iRESET_SYNC;
   logic        iDATA_REQ;
   logic        oDATA_BUSY;
   logic        iDATA_SIGN;
   logic [9:0]  iDATA_EXP;
   logic [47:0] iDATA_FRACT;
   logic        iDATA_EXCEPT_EXP_A0, iDATA_EXCEPT_EXP_B0;
   logic        iDATA_EXCEPT_EXP_A1, iDATA_EXCEPT_EXP_B1;
   logic        iDATA_EXCEPT_FRACT_A0, iDATA_EXCEPT_FRACT_B0;
   logic        oDATA_VALID;
   logic        iDATA_BUSY;
   logic [31:0] oDATA_RESULT;
   logic        oDATA_OVERFLOW, oDATA_UNDERFLOW, oDATA_INEXACT, oDATA_INVALID;

   always #5 iCLOCK = ~iCLOCK;

   mul_float_norm dut (
      .iCLOCK                (iCLOCK),
      .inRESET               (inRESET),
      .iRESET_SYNC           (iRESET_SYNC),
      .iDATA_REQ             (iDATA_REQ),
      .oDATA_BUSY            (oDATA_BUSY),
      .iDATA_SIGN            (iDATA_SIGN),
      .iDATA_EXP             (iDATA_EXP),
      .iDATA_FRACT           (iDATA_FRACT),
      .iDATA_EXCEPT_EXP_A0   (iDATA_EXCEPT_EXP_A0),
      .iDATA_EXCEPT_EXP_B0   (iDATA_EXCEPT_EXP_B0),
      .iDATA_EXCEPT_EXP_A1   (iDATA_EXCEPT_EXP_A1),
      .iDATA_EXCEPT_EXP_B1   (iDATA_EXCEPT_EXP_B1),
      .iDATA_EXCEPT_FRACT_A0 (iDATA_EXCEPT_FRACT_A0),
      .iDATA_EXCEPT_FRACT_B0 (iDATA_EXCEPT_FRACT_B0),
      .oDATA_VALID           (oDATA_VALID),
      .iDATA_BUSY            (iDATA_BUSY),
      .oDATA_RESULT          (oDATA_RESULT),
      .oDATA_OVERFLOW        (oDATA_OVERFLOW),
      .oDATA_UNDERFLOW       (oDATA_UNDERFLOW),
      .oDATA_INEXACT         (oDATA_INEXACT),
      .oDATA_INVALID         (oDATA_INVALID)
   );

   // result word with flags {overflow, underflow, inexact, invalid} in the low nibble
   logic [35:0] dut_out;
   assign dut_out = {oDATA_RESULT, oDATA_OVERFLOW, oDATA_UNDERFLOW, oDATA_INEXACT, oDATA_INVALID};

   int checks = 0;
   int errors = 0;

   // exc bit order: {EXP_A0, EXP_B0, EXP_A1, EXP_B1, FRACT_A0, FRACT_B0}
   typedef struct {
      string       name;
      logic        sign;
      logic [9:0]  exp;
      logic [47:0] fract;
      logic [5:0]  exc;
      logic [31:0] res;
      logic [3:0]  flg;
   } vec_t;

   vec_t vecs[$];
   logic [35:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] f, input logic [5:0] x);
      iDATA_SIGN  = s;
      iDATA_EXP   = e;
      iDATA_FRACT = f;
      {iDATA_EXCEPT_EXP_A0, iDATA_EXCEPT_EXP_B0, iDATA_EXCEPT_EXP_A1,
       iDATA_EXCEPT_EXP_B1, iDATA_EXCEPT_FRACT_A0, iDATA_EXCEPT_FRACT_B0} = x;
      iDATA_REQ   = 1'b1;
   endtask

   // Numeric reference: value = fract * 2^(exp-127-46); round the 48-bit integer to a
   // 24-bit significand with nearest-even, then apply the FP32 exponent range.
   function automatic logic [35:0] model(input logic s, input logic [9:0] e_in,
                                         input logic [47:0] fr, input logic [5:0] x);
      logic a0, b0, a1, b1, fa0, fb0;
      longint unsigned f, q, rem, half;
      int sh, e;
      logic [7:0] e8;
      {a0, b0, a1, b1, fa0, fb0} = x;
      if ((a1 && !fa0) || (b1 && !fb0) || (a1 && fa0 && b0) || (b1 && fb0 && a0))
         return {32'h7FC0_0000, 4'b0001};
      if ((a1 && fa0) || (b1 && fb0))
         return {s, 8'hFF, 23'h0, 4'b0000};
      if (a0 || b0)
         return {s, 31'h0, 4'b0000};
      f    = longint'(fr);
      sh   = (f >= 64'h8000_0000_0000) ? 24 : 23;
      q    = f >> sh;
      rem  = f - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      e = int'($signed(e_in)) + (sh - 23);
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0, 4'b1010};
      if (e <= 0)   return {s, 31'h0, 4'b0110};
      e8 = e[7:0];
      return {s, e8, q[22:0], 2'b00, (rem != 0), 1'b0};
   endfunction

   // One request on an idle pipe: nothing one edge after capture, result one edge later
   task automatic run_vec(input vec_t v);
      @(posedge iCLOCK); #1;
      drive(v.sign, v.exp, v.fract, v.exc);
      @(posedge iCLOCK); #1;
      iDATA_REQ = 1'b0;
      @(negedge iCLOCK);
      chk({v.name, "_lat1_valid"}, 64'(oDATA_VALID), 64'd0);
      @(negedge iCLOCK);
      chk({v.name, "_valid"}, 64'(oDATA_VALID), 64'd1);
      chk(v.name, 64'(dut_out), 64'({v.res, v.flg}));
      @(posedge iCLOCK); #1;
   endtask

   task automatic gen_operand(output logic ez, output logic e1, output logic fz, output logic [23:0] sig);
      int k;
      k   = $urandom_range(0, 15);
      sig = 24'h80_0000 | 24'($urandom_range(0, 24'h7F_FFFF));
      ez = 1'b0; e1 = 1'b0; fz = 1'b0;
      if (k == 0) begin ez = 1'b1; fz = $urandom_range(0, 1) == 1; end
      else if (k == 1) begin e1 = 1'b1; fz = 1'b1; end
      else if (k == 2) begin e1 = 1'b1; end
   endtask

   initial begin
      logic [31:0] held;
      int sent, cycles, n_rand;
      logic pending;
      logic [35:0] want;
      logic a0, b0, a1, b1, fa0, fb0;
      logic [23:0] sa, sb;
      logic [47:0] fr;
      logic [9:0] ex;

      inRESET = 1'b0; iRESET_SYNC = 1'b0; iDATA_BUSY = 1'b0;
      drive(1'b0, 10'd0, 48'd0, 6'd0);
      iDATA_REQ = 1'b0;

      vecs.push_back('{"mul1p5",     1'b0, 10'd127, 48'h9000_0000_0000, 6'b000000, 32'h4010_0000, 4'b0000});
      vecs.push_back('{"tie_even",   1'b0, 10'd127, 48'h4000_0040_0000, 6'b000000, 32'h3F80_0000, 4'b0010});
      vecs.push_back('{"tie_up",     1'b0, 10'd127, 48'h4000_00C0_0000, 6'b000000, 32'h3F80_0002, 4'b0010});
      vecs.push_back('{"overflow",   1'b0, 10'd254, 48'h8000_0000_0000, 6'b000000, 32'h7F80_0000, 4'b1010});
      vecs.push_back('{"underflow",  1'b1, 10'h3F0, 48'h4000_0000_0000, 6'b000000, 32'h8000_0000, 4'b0110});
      vecs.push_back('{"inf_x_zero", 1'b0, 10'd127, 48'h4000_0000_0000, 6'b011010, 32'h7FC0_0000, 4'b0001});
      vecs.push_back('{"nan_a",      1'b0, 10'd127, 48'h4000_0000_0000, 6'b001000, 32'h7FC0_0000, 4'b0001});
      vecs.push_back('{"inf_neg",    1'b1, 10'd127, 48'h4000_0000_0000, 6'b001010, 32'hFF80_0000, 4'b0000});
      vecs.push_back('{"zero_neg",   1'b1, 10'd127, 48'h4000_0000_0000, 6'b100000, 32'h8000_0000, 4'b0000});
      vecs.push_back('{"rnd_carry",  1'b0, 10'd127, 48'h7FFF_FFC0_0000, 6'b000000, 32'h4000_0000, 4'b0010});
      vecs.push_back('{"ovf_by_rnd", 1'b0, 10'd254, 48'h7FFF_FFC0_0000, 6'b000000, 32'h7F80_0000, 4'b1010});
      vecs.push_back('{"unf_exp0",   1'b0, 10'd0,   48'h4000_0000_0000, 6'b000000, 32'h0000_0000, 4'b0110});
      vecs.push_back('{"min_norm",   1'b0, 10'd1,   48'h4000_0000_0000, 6'b000000, 32'h0080_0000, 4'b0000});
      vecs.push_back('{"max_norm",   1'b0, 10'd254, 48'h7FFF_FF80_0000, 6'b000000, 32'h7F7F_FFFF, 4'b0000});

      // reset state
      #12;
      chk("rst_valid", 64'(oDATA_VALID), 64'd0);
      chk("rst_out", 64'(dut_out), 64'd0);
      @(negedge iCLOCK); inRESET = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // downstream stall across three back-to-back requests
      drive(vecs[0].sign, vecs[0].exp, vecs[0].fract, vecs[0].exc);
      @(posedge iCLOCK); #1;
      drive(vecs[1].sign, vecs[1].exp, vecs[1].fract, vecs[1].exc);
      @(posedge iCLOCK); #1;
      drive(vecs[2].sign, vecs[2].exp, vecs[2].fract, vecs[2].exc);
      iDATA_BUSY = 1'b1;
      @(negedge iCLOCK);
      chk("stall_busy_mirror", 64'(oDATA_BUSY), 64'd1);
      chk("stall_a_valid", 64'(oDATA_VALID), 64'd1);
      chk("stall_a", 64'(dut_out), 64'({vecs[0].res, vecs[0].flg}));
      for (int c = 0; c < 2; c++) begin
         @(posedge iCLOCK); #1;
         if (c == 1) iDATA_BUSY = 1'b0;
         @(negedge iCLOCK);
         chk("stall_a_held_valid", 64'(oDATA_VALID), 64'd1);
         chk("stall_a_held", 64'(dut_out), 64'({vecs[0].res, vecs[0].flg}));
      end
      chk("stall_busy_release", 64'(oDATA_BUSY), 64'd0);
      @(posedge iCLOCK); #1;
      iDATA_REQ = 1'b0;
      @(negedge iCLOCK);
      chk("stall_b", 64'({oDATA_VALID, dut_out}), 64'({1'b1, vecs[1].res, vecs[1].flg}));
      @(negedge iCLOCK);
      chk("stall_c", 64'({oDATA_VALID, dut_out}), 64'({1'b1, vecs[2].res, vecs[2].flg}));
      @(negedge iCLOCK);
      chk("stall_drained", 64'(oDATA_VALID), 64'd0);

      // async reset with two results in flight
      @(posedge iCLOCK); #1;
      drive(vecs[0].sign, vecs[0].exp, vecs[0].fract, vecs[0].exc);
      @(posedge iCLOCK); #1;
      drive(vecs[2].sign, vecs[2].exp, vecs[2].fract, vecs[2].exc);
      @(posedge iCLOCK); #1;
      iDATA_REQ = 1'b0;
      inRESET = 1'b0;
      #1;
      chk("arst_valid", 64'(oDATA_VALID), 64'd0);
      chk("arst_out", 64'(dut_out), 64'd0);
      @(negedge iCLOCK); inRESET = 1'b1;
      run_vec(vecs[13]);

      // sync reset with two results in flight
      drive(vecs[0].sign, vecs[0].exp, vecs[0].fract, vecs[0].exc);
      @(posedge iCLOCK); #1;
      drive(vecs[2].sign, vecs[2].exp, vecs[2].fract, vecs[2].exc);
      @(posedge iCLOCK); #1;
      iDATA_REQ = 1'b0;
      iRESET_SYNC = 1'b1;
      @(posedge iCLOCK); #1;
      iRESET_SYNC = 1'b0;
      @(negedge iCLOCK);
      chk("srst_valid", 64'(oDATA_VALID), 64'd0);
      chk("srst_out", 64'(dut_out), 64'd0);
      @(negedge iCLOCK);
      chk("srst_stays_empty", 64'(oDATA_VALID), 64'd0);
      run_vec(vecs[9]);

      // randomized traffic with random stalls against the model
      n_rand = 400; sent = 0; cycles = 0; pending = 1'b0;
      held = 32'h0;
      while ((sent < n_rand || exp_q.size() != 0 || pending) && cycles < 20000) begin
         @(posedge iCLOCK); #1;
         cycles++;
         iDATA_BUSY = ($urandom_range(0, 3) == 0);
         if (!pending && sent < n_rand && $urandom_range(0, 3) != 0) begin
            gen_operand(a0, a1, fa0, sa);
            gen_operand(b0, b1, fb0, sb);
            fr = sa * sb;
            if ($urandom_range(0, 3) == 0) fr[21:0] = 22'h0;
            case ($urandom_range(0, 3))
               0: ex = 10'($urandom_range(0, 1023));
               1: ex = 10'(252 + $urandom_range(0, 4));
               2: ex = 10'(-2 + int'($urandom_range(0, 4)));
               default: ex = 10'($urandom_range(1, 253));
            endcase
            drive(1'($urandom_range(0, 1)), ex, fr, {a0, b0, a1, b1, fa0, fb0});
            pending = 1'b1;
            sent++;
         end
         @(negedge iCLOCK);
         chk("rnd_busy_mirror", 64'(oDATA_BUSY), 64'(iDATA_BUSY));
         if (oDATA_VALID && !iDATA_BUSY) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rnd_unexpected_output actual=%h required=none", dut_out);
            end else begin
               want = exp_q.pop_front();
               chk("rnd_result", 64'(dut_out), 64'(want));
            end
         end
         if (pending && !iDATA_BUSY) begin
            exp_q.push_back(model(iDATA_SIGN, iDATA_EXP, iDATA_FRACT,
                                  {iDATA_EXCEPT_EXP_A0, iDATA_EXCEPT_EXP_B0, iDATA_EXCEPT_EXP_A1,
                                   iDATA_EXCEPT_EXP_B1, iDATA_EXCEPT_FRACT_A0, iDATA_EXCEPT_FRACT_B0}));
            pending = 1'b0;
            @(posedge iCLOCK); #1;
            iDATA_REQ = 1'b0;
            @(negedge iCLOCK);
            chk("rnd_busy_mirror", 64'(oDATA_BUSY), 64'(iDATA_BUSY));
            if (oDATA_VALID && !iDATA_BUSY) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL rnd_unexpected_output actual=%h required=none", dut_out);
               end else begin
                  want = exp_q.pop_front();
                  chk("rnd_result", 64'(dut_out), 64'(want));
               end
            end
         end
      end
      chk("rnd_all_sent", 64'(sent), 64'(n_rand));
      chk("rnd_none_lost", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
